// File: rtl/axi8_lite_master.sv
// Single-byte AXI-lite-style initiator: a command in, AW/W/B or AR/R handshakes on the pins,
// and a response out. A per-phase timeout makes sure an absent target cannot stall it.
module axi8_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       m_awvalid,
    input  logic       m_awready,
    output logic       m_wvalid,
    input  logic       m_wready,
    input  logic       m_bvalid,
    output logic       m_bready,
    output logic       m_arvalid,
    input  logic       m_arready,
    input  logic       m_rvalid,
    output logic       m_rready,
    output logic       m_addr,
    output logic       m_wstrb,
    output logic [7:0] m_wdata,
    input  logic [7:0] m_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [7:0] cnt_q, cnt_d;
    logic       addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       timeout;
    logic       abort;

    // Last wait cycle of a phase: abort unless the phase completes on this same edge.
    assign timeout = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        abort     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                aw_done_d = aw_done_q | m_awready;
                w_done_d  = w_done_q | m_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_B;
                    cnt_d   = '0;
                end else if (timeout) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_B: begin
                if (m_bvalid) begin
                    state_d = RSP;
                    cnt_d   = '0;
                end else if (timeout) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_AR: begin
                if (m_arready) begin
                    state_d = RD_R;
                    cnt_d   = '0;
                end else if (timeout) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_R: begin
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    state_d = RSP;
                    cnt_d   = '0;
                end else if (timeout) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    addr_d  = 1'b0;
                    wdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = RSP;
            cnt_d   = '0;
            err_d   = 1'b1;
            rdata_d = '0;
        end
    end

    // Every pin output comes from state or registers, never from a target input.
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign m_awvalid = (state_q == WR_AW_W) && !aw_done_q;
    assign m_wvalid  = (state_q == WR_AW_W) && !w_done_q;
    assign m_wstrb   = (state_q == WR_AW_W);
    assign m_bready  = (state_q == WR_B);
    assign m_arvalid = (state_q == RD_AR);
    assign m_rready  = (state_q == RD_R);
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_axi8_lite_master.sv
// Randomized scoreboard bench for axi8_lite_master with a latency-programmable stand-in target
// (reg 0 writable, reg 1 reads back the inverse of reg 0).
module tb_axi8_lite_master;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic       m_arvalid, m_arready, m_rvalid, m_rready, m_addr, m_wstrb;
    logic [7:0] m_wdata, m_rdata;

    always #5 clk = ~clk;

    axi8_lite_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t       sb_q[$];
    int         n_chk = 0, n_fail = 0;
    int         lat_aw = 0, lat_w = 0, lat_b = 0, lat_ar = 0, lat_r = 0;
    bit         tgt_flush = 1'b0;
    logic [7:0] tgt_reg = 8'h00;
    logic [7:0] ref_reg = 8'h00;
    bit         chk_en = 1'b0;
    logic       cur_addr = 1'b0;
    logic [7:0] cur_wdata = 8'h00;
    int         cyc = 0, aw_drop = -1, w_drop = -1, ar_hi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outvec();
        return {6'b0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_addr, m_wstrb,
                m_wdata, cmd_ready, rsp_valid, rsp_rdata, rsp_err};
    endfunction

    // Stand-in target: handshakes are inferred from the levels held across the preceding posedge.
    initial begin : target
        bit         p_aw, p_w, p_b, p_ar, p_r, p_addr;
        logic [7:0] p_wdata, d_w, d_r;
        bit         hs_aw, hs_w, hs_b, hs_ar, hs_r;
        bit         aw_got, w_got, b_pend, r_pend, a_aw;
        int         c_aw, c_w, c_b, c_ar, c_r;
        {p_aw, p_w, p_b, p_ar, p_r, p_addr} = '0;
        {aw_got, w_got, b_pend, r_pend, a_aw} = '0;
        {c_aw, c_w, c_b, c_ar, c_r} = '0;
        p_wdata = 8'h00; d_w = 8'h00; d_r = 8'h00;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n || tgt_flush) begin
                m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
                m_arready = 1'b0; m_rvalid = 1'b0;
                {aw_got, w_got, b_pend, r_pend} = '0;
                {c_aw, c_w, c_b, c_ar, c_r} = '0;
                tgt_flush = 1'b0;
            end else begin
                hs_aw = p_aw && m_awready;
                hs_w  = p_w && m_wready;
                hs_b  = p_b && m_bvalid;
                hs_ar = p_ar && m_arready;
                hs_r  = p_r && m_rvalid;

                if (hs_aw) begin aw_got = 1'b1; a_aw = p_addr; m_awready = 1'b0; c_aw = 0; end
                else if (m_awvalid === 1'b1) begin if (c_aw >= lat_aw) m_awready = 1'b1; else c_aw++; end
                else begin m_awready = 1'b0; c_aw = 0; end

                if (hs_w) begin w_got = 1'b1; d_w = p_wdata; m_wready = 1'b0; c_w = 0; end
                else if (m_wvalid === 1'b1) begin if (c_w >= lat_w) m_wready = 1'b1; else c_w++; end
                else begin m_wready = 1'b0; c_w = 0; end

                if (aw_got && w_got) begin
                    if (!a_aw) tgt_reg = d_w;
                    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; c_b = 0;
                end else if (m_awvalid !== 1'b1 && m_wvalid !== 1'b1) begin
                    aw_got = 1'b0; w_got = 1'b0;
                end

                if (hs_b) begin m_bvalid = 1'b0; b_pend = 1'b0; end
                else if (b_pend) begin if (c_b >= lat_b) m_bvalid = 1'b1; else c_b++; end

                if (hs_ar) begin
                    r_pend = 1'b1; c_r = 0; m_arready = 1'b0; c_ar = 0;
                    d_r = p_addr ? ~tgt_reg : tgt_reg;
                end
                else if (m_arvalid === 1'b1) begin if (c_ar >= lat_ar) m_arready = 1'b1; else c_ar++; end
                else begin m_arready = 1'b0; c_ar = 0; end

                if (hs_r) begin m_rvalid = 1'b0; r_pend = 1'b0; end
                else if (r_pend) begin
                    if (c_r >= lat_r) begin m_rvalid = 1'b1; m_rdata = d_r; end else c_r++;
                end
            end
            if (!m_rvalid) m_rdata = 8'($urandom);
            p_aw = (m_awvalid === 1'b1); p_w = (m_wvalid === 1'b1); p_b = (m_bready === 1'b1);
            p_ar = (m_arvalid === 1'b1); p_r = (m_rready === 1'b1);
            p_addr = (m_addr === 1'b1); p_wdata = m_wdata;
        end
    end

    // Scoreboard monitor: every response handshake pops one expectation.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    // Pin watcher: payload stability, valid-drop timing and arvalid occupancy.
    initial begin : watch
        bit p_awv, p_wv;
        p_awv = 1'b0; p_wv = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (p_awv && m_awvalid !== 1'b1) aw_drop = cyc;
            if (p_wv && m_wvalid !== 1'b1) w_drop = cyc;
            if (m_arvalid === 1'b1) ar_hi++;
            p_awv = (m_awvalid === 1'b1);
            p_wv  = (m_wvalid === 1'b1);
            if (chk_en) begin
                if (cmd_ready === 1'b1) begin
                    chk("idle_payload", {23'b0, m_addr, m_wdata}, 32'd0);
                end else begin
                    chk("held_payload", {23'b0, m_addr, m_wdata}, {23'b0, cur_addr, cur_wdata});
                end
            end
        end
    end

    task automatic flush_target();
        tgt_flush = 1'b1;
        while (tgt_flush) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1 with the DUT idle; returns edges from accept to response handshake.
    task automatic issue(input bit wr, input bit a, input logic [7:0] d,
                         input int law, input int lw, input int lb, input int lar, input int lr,
                         input int hold, output int lat);
        rsp_t e;
        bit   aw_w_fail;
        int   t, h;
        lat_aw = law; lat_w = lw; lat_b = lb; lat_ar = lar; lat_r = lr;
        aw_drop = -1; w_drop = -1; ar_hi = 0;
        if (wr) begin
            aw_w_fail = ((law > lw) ? law : lw) >= TO;
            e.err   = aw_w_fail || (lb >= TO);
            e.rdata = 8'h00;
            if (!aw_w_fail && !a) ref_reg = d;
        end else begin
            e.err   = (lar >= TO) || (lr >= TO);
            e.rdata = e.err ? 8'h00 : (a ? ~ref_reg : ref_reg);
        end
        sb_q.push_back(e);
        cur_addr = a; cur_wdata = d;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_wdata = 8'($urandom);
        t = 0; lat = -1;
        while (t < 60 && lat < 0) begin
            if (rsp_valid === 1'b1 && hold > 0) begin
                for (h = 0; h < hold; h++) begin
                    chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
                    @(posedge clk); #1; t++;
                end
                hold = 0;
                rsp_ready = 1'b1;
            end else if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                lat = t + 1;
            end else begin
                @(posedge clk); #1; t++;
            end
        end
        if (lat < 0) chk("rsp_wait_bound", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        flush_target();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, k;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 1'b0;
        cmd_wdata = 8'h00; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outvec(), 32'h400);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Late AW, immediate W: W must drop two cycles before AW.
        issue(1'b1, 1'b0, 8'h5A, 2, 0, 1, 0, 0, 0, lat);
        chk("w_drops_before_aw", 32'(aw_drop - w_drop), 32'd2);

        // Ideal target: write then read of the inverted register.
        issue(1'b1, 1'b0, 8'h5A, 0, 0, 0, 0, 0, 0, lat);
        chk("ideal_write_latency", 32'(lat), 32'd3);
        issue(1'b0, 1'b1, 8'hE7, 0, 0, 0, 0, 0, 0, lat);
        chk("ideal_read_latency", 32'(lat), 32'd3);

        // Silent AR: abort after TO waiting cycles.
        issue(1'b0, 1'b0, 8'h11, 0, 0, 0, 255, 0, 0, lat);
        chk("arvalid_cycles", 32'(ar_hi), 32'(TO));
        chk("idle_after_abort", 32'(cmd_ready), 32'd1);

        // Response back-pressure on a read of 0x3C.
        issue(1'b1, 1'b0, 8'h3C, 0, 0, 0, 0, 0, 0, lat);
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 5, lat);

        // Reset while waiting in WR_B, then a normal write and read-back.
        lat_aw = 0; lat_w = 0; lat_b = 255; lat_ar = 0; lat_r = 0;
        cur_addr = 1'b0; cur_wdata = 8'h77;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 1'b0; cmd_wdata = 8'h77;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (k < 20 && m_bready !== 1'b1) begin @(posedge clk); #1; k++; end
        chk("reached_wr_b", 32'(m_bready), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset_outputs", outvec(), 32'h400);
        rst_n = 1'b1;
        ref_reg = 8'h77;
        flush_target();
        issue(1'b1, 1'b0, 8'h81, 0, 0, 0, 0, 0, 0, lat);
        chk("post_reset_write_latency", 32'(lat), 32'd3);
        issue(1'b0, 1'b1, 8'h00, 0, 0, 0, 0, 0, 0, lat);

        for (int i = 0; i < 40; i++) begin
            bit wr, a, ideal;
            logic [7:0] d;
            int l0, l1, l2, l3, l4;
            wr = 1'($urandom_range(0, 1));
            a  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            ideal = ($urandom_range(0, 2) == 0);
            l0 = ideal ? 0 : int'($urandom_range(0, 5));
            l1 = ideal ? 0 : int'($urandom_range(0, 5));
            l2 = ideal ? 0 : int'($urandom_range(0, 5));
            l3 = ideal ? 0 : int'($urandom_range(0, 5));
            l4 = ideal ? 0 : int'($urandom_range(0, 5));
            issue(wr, a, d, l0, l1, l2, l3, l4, 0, lat);
            if (ideal) chk("random_ideal_latency", 32'(lat), 32'd3);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
